// File: rtl/ads_result_display.sv
// ads_result_display: signed ADS1115 result to six active-low 7-segment digits.
// Sequential double-dabble BCD conversion, sign digit plus five decimal digits.
//
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   synchronous active-low reset
//   in_valid       in   in_data holds a new conversion result
//   in_ready       out  high in IDLE; transfer on in_valid & in_ready at clk edge
//   in_data[15:0]  in   ADS1115 result, two's complement
//   done           out  one-cycle pulse when the display registers update
//   led1_export    out  units digit (active-low, bit0 = a .. bit6 = g)
//   led2_export    out  tens digit
//   led3_export    out  hundreds digit
//   led4_export    out  thousands digit
//   led5_export    out  ten-thousands digit
//   led6_export    out  sign digit (minus or blank)

module ads_result_display #(
   parameter int unsigned SCALE_SHIFT   = 3,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        done,
   output logic [6:0]  led1_export,
   output logic [6:0]  led2_export,
   output logic [6:0]  led3_export,
   output logic [6:0]  led4_export,
   output logic [6:0]  led5_export,
   output logic [6:0]  led6_export
);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      UPDATE
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        sign;
   logic [15:0] mag;
   logic [19:0] bcd;
   logic [4:0]  cnt;
   logic [15:0] abs_in;
   logic [15:0] adj_lo;
   logic        accept;

   logic [3:0]  dig1;
   logic [3:0]  dig2;
   logic [3:0]  dig3;
   logic [3:0]  dig4;
   logic [3:0]  dig5;
   logic        blank2;
   logic        blank3;
   logic        blank4;
   logic        blank5;
   logic [6:0]  seg1;
   logic [6:0]  seg2;
   logic [6:0]  seg3;
   logic [6:0]  seg4;
   logic [6:0]  seg5;
   logic [6:0]  seg6;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;

   // 16-bit unsigned magnitude; 0x8000 wraps back to 0x8000 = 32768.
   assign abs_in = in_data[15] ? (~in_data + 16'd1) : in_data;

   // Add-3 on the four low nibbles. The ten-thousands nibble is never
   // adjusted: the partial value before any shift is at most 32767,
   // so that digit is at most 3 and never needs correction.
   always_comb begin
      adj_lo = bcd[15:0];
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj_lo[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digit split and leading-zero blanking.
   assign dig1 = bcd[3:0];
   assign dig2 = bcd[7:4];
   assign dig3 = bcd[11:8];
   assign dig4 = bcd[15:12];
   assign dig5 = bcd[19:16];

   assign blank5 = BLANK_LEADING && (dig5 == 4'd0);
   assign blank4 = blank5 && (dig4 == 4'd0);
   assign blank3 = blank4 && (dig3 == 4'd0);
   assign blank2 = blank3 && (dig2 == 4'd0);

   assign seg1 = seg7(dig1);
   assign seg2 = blank2 ? SEG_BLANK : seg7(dig2);
   assign seg3 = blank3 ? SEG_BLANK : seg7(dig3);
   assign seg4 = blank4 ? SEG_BLANK : seg7(dig4);
   assign seg5 = blank5 ? SEG_BLANK : seg7(dig5);

   // A negative value that scales to zero is shown as plain 0.
   assign seg6 = (sign && (bcd != 20'd0)) ? SEG_MINUS : SEG_BLANK;

   // State register.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            if (cnt == 5'd15) begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Conversion datapath and display registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sign        <= 1'b0;
         mag         <= 16'd0;
         bcd         <= 20'd0;
         cnt         <= 5'd0;
         done        <= 1'b0;
         led1_export <= SEG_BLANK;
         led2_export <= SEG_BLANK;
         led3_export <= SEG_BLANK;
         led4_export <= SEG_BLANK;
         led5_export <= SEG_BLANK;
         led6_export <= SEG_BLANK;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sign <= in_data[15];
                  mag  <= abs_in >> SCALE_SHIFT;
                  bcd  <= 20'd0;
                  cnt  <= 5'd0;
               end
            end
            CONVERT: begin
               bcd <= {bcd[18:16], adj_lo, mag[15]};
               mag <= {mag[14:0], 1'b0};
               cnt <= cnt + 5'd1;
            end
            UPDATE: begin
               led1_export <= seg1;
               led2_export <= seg2;
               led3_export <= seg3;
               led4_export <= seg4;
               led5_export <= seg5;
               led6_export <= seg6;
               done        <= 1'b1;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ads_result_display.sv
// tb_ads_result_display: directed and random samples through three
// parameter variants of ads_result_display, checked against a decimal model.

module tb_ads_result_display;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        rdy [3];
   logic        dn  [3];
   logic [6:0]  led [3][6];

   int checks   = 0;
   int failures = 0;

   localparam int SH [3] = '{0, 3, 0};
   localparam bit BL [3] = '{1'b1, 1'b1, 1'b0};

   logic [15:0] shown;
   bit          shown_ok;

   always #5 clk = ~clk;

   ads_result_display #(.SCALE_SHIFT(0), .BLANK_LEADING(1'b1)) dut0 (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
      .done(dn[0]),
      .led1_export(led[0][0]), .led2_export(led[0][1]),
      .led3_export(led[0][2]), .led4_export(led[0][3]),
      .led5_export(led[0][4]), .led6_export(led[0][5])
   );

   ads_result_display #(.SCALE_SHIFT(3), .BLANK_LEADING(1'b1)) dut1 (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
      .done(dn[1]),
      .led1_export(led[1][0]), .led2_export(led[1][1]),
      .led3_export(led[1][2]), .led4_export(led[1][3]),
      .led5_export(led[1][4]), .led6_export(led[1][5])
   );

   ads_result_display #(.SCALE_SHIFT(0), .BLANK_LEADING(1'b0)) dut2 (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
      .done(dn[2]),
      .led1_export(led[2][0]), .led2_export(led[2][1]),
      .led3_export(led[2][2]), .led4_export(led[2][3]),
      .led5_export(led[2][4]), .led6_export(led[2][5])
   );

   function automatic logic [6:0] seg(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tbl[d];
   endfunction

   // Expected pattern for display position pos (1 = units .. 6 = sign).
   function automatic logic [6:0] exp_led(input logic [15:0] x,
                                          input int sh, input bit bl,
                                          input int pos);
      int v;
      int p10;
      v = x[15] ? (65536 - int'(x)) : int'(x);
      v = v >> sh;
      if (pos == 6) return (x[15] && v != 0) ? 7'h3F : 7'h7F;
      p10 = 1;
      for (int i = 1; i < pos; i++) p10 = p10 * 10;
      if (bl && pos > 1 && v < p10) return 7'h7F;
      return seg((v / p10) % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_display(input string tag);
      logic [6:0] e;
      for (int d = 0; d < 3; d++) begin
         for (int p = 0; p < 6; p++) begin
            e = shown_ok ? exp_led(shown, SH[d], BL[d], p + 1) : 7'h7F;
            chk($sformatf("%s_dut%0d_led%0d", tag, d, p + 1),
                32'(led[d][p]), 32'(e));
         end
      end
   endtask

   // One full conversion; optional noise on in_valid while busy.
   task automatic run(input logic [15:0] x, input bit noise);
      int k;
      @(negedge clk);
      chk("ready_idle", 32'(rdy[0]), 32'd1);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         in_valid = noise && i >= 3 && i <= 10;
         if (in_valid) in_data = 16'($urandom);
         @(negedge clk);
         if (i == 8) begin
            for (int d = 0; d < 3; d++)
               chk($sformatf("ready_busy_dut%0d", d), 32'(rdy[d]), 32'd0);
         end
         if (i == 9) check_display("hold");
         if (dn[0]) begin
            k = i;
            break;
         end
      end
      chk("latency", k, 17);
      chk("done_dut1", 32'(dn[1]), 32'd1);
      chk("done_dut2", 32'(dn[2]), 32'd1);
      chk("ready_after", 32'(rdy[0]), 32'd1);
      shown    = x;
      shown_ok = 1'b1;
      check_display($sformatf("val_%04h", x));
      @(negedge clk);
      chk("done_pulse_end", 32'(dn[0]), 32'd0);
   endtask

   initial begin
      int acc;
      int lowcnt;
      int dcount;
      logic [15:0] x;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'd0;
      shown    = 16'd0;
      shown_ok = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_display("reset");
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_ready_dut%0d", d), 32'(rdy[d]), 32'd1);
         chk($sformatf("reset_done_dut%0d", d), 32'(dn[d]), 32'd0);
      end
      rst_n = 1'b1;

      run(16'h7FFF, 1'b0);
      run(16'h8000, 1'b1);
      run(16'h1F40, 1'b0);
      run(16'hFFFD, 1'b1);
      run(16'h0000, 1'b0);
      run(16'hFFFF, 1'b0);
      run(16'hFFF8, 1'b0);
      run(16'h0007, 1'b1);

      // in_valid held high: accepts only when idle.
      x = 16'($urandom);
      @(negedge clk);
      in_data  = x;
      in_valid = 1'b1;
      acc    = 0;
      lowcnt = 0;
      dcount = 0;
      for (int i = 0; i < 36; i++) begin
         if (rdy[0]) begin
            acc++;
            if (acc == 2) chk("second_accept_edge", i, 18);
         end else begin
            lowcnt++;
         end
         if (dn[0]) dcount++;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         if (dn[0]) dcount++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("hold_accepts", acc, 2);
      chk("hold_ready_low", lowcnt, 34);
      chk("hold_dones", dcount, 2);
      shown    = x;
      shown_ok = 1'b1;
      check_display("hold_valid");

      // Reset in the middle of a conversion.
      @(negedge clk);
      in_data  = 16'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      shown_ok = 1'b0;
      check_display("midreset");
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("midreset_ready_dut%0d", d), 32'(rdy[d]), 32'd1);
         chk($sformatf("midreset_done_dut%0d", d), 32'(dn[d]), 32'd0);
      end
      dcount = 0;
      for (int j = 0; j < 25; j++) begin
         if (dn[0] || dn[1] || dn[2]) dcount++;
         @(negedge clk);
      end
      chk("midreset_no_done", dcount, 0);

      for (int n = 0; n < 12; n++) run(16'($urandom), n[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
